// File: rtl/arm_cpu_core_if.sv
// Bus between the LEGv8 core and its external instruction ROM / data memory.
//   instruction      : instruction word at the current PC (combinational from ROM)
//   mem_data_out     : data memory read data (combinational)
//   PC               : current program counter
//   mem_address      : data memory byte address
//   mem_data_in      : store data towards data memory
//   control_memwrite : store strobe, high for the whole STUR cycle
//   control_memread  : load enable, high for the whole LDUR cycle
// The master modport is the core side, the slave modport is the memory side.
interface arm_cpu_core_if #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned INSTR_W = 32
);
    logic [INSTR_W-1:0] instruction;
    logic [DATA_W-1:0]  mem_data_out;
    logic [DATA_W-1:0]  PC;
    logic [DATA_W-1:0]  mem_address;
    logic [DATA_W-1:0]  mem_data_in;
    logic               control_memwrite;
    logic               control_memread;

    modport master (
        input  instruction,
        input  mem_data_out,
        output PC,
        output mem_address,
        output mem_data_in,
        output control_memwrite,
        output control_memread
    );

    modport slave (
        output instruction,
        output mem_data_out,
        input  PC,
        input  mem_address,
        input  mem_data_in,
        input  control_memwrite,
        input  control_memread
    );
endinterface

// File: rtl/arm_cpu_core.sv
// Single-cycle 64-bit LEGv8 core: one instruction fetched, decoded, executed and retired per
// rising CLOCK edge. Holds PC, a 32x64 register file (X31 = XZR), ALU and branch logic; the
// instruction ROM and data memory are external and reached through the bus interface.
// Ports:
//   CLOCK : single clock, all state updates on the rising edge
//   RESET : asynchronous, active-low; clears PC and X0..X30 and forces memory outputs to 0
//   bus   : arm_cpu_core_if master (instruction / memory handshake)
// Supported: ADD, SUB, AND, ORR, LDUR, STUR, CBZ, B. Anything else executes as a NOP.
module arm_cpu_core #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned NREGS   = 32
) (
    input  logic           CLOCK,
    input  logic           RESET,
    arm_cpu_core_if.master bus
);

    localparam logic [10:0] OpAdd  = 11'b10001011000;
    localparam logic [10:0] OpSub  = 11'b11001011000;
    localparam logic [10:0] OpAnd  = 11'b10001010000;
    localparam logic [10:0] OpOrr  = 11'b10101010000;
    localparam logic [10:0] OpLdur = 11'b11111000010;
    localparam logic [10:0] OpStur = 11'b11111000000;
    localparam logic [7:0]  OpCbz  = 8'b10110100;
    localparam logic [5:0]  OpB    = 6'b000101;
    localparam logic [4:0]  Xzr    = 5'd31;

    typedef enum logic [1:0] {AluAdd, AluSub, AluAnd, AluOrr} alu_op_e;

    logic [DATA_W-1:0]  pc_q, pc_d;
    logic [DATA_W-1:0]  regs_q [NREGS];
    logic [INSTR_W-1:0] instr;

    logic [4:0]        rn, rm, rd;
    logic              is_r, is_ldur, is_stur, is_cbz, is_b;
    alu_op_e           alu_op;
    logic [DATA_W-1:0] rn_val, rb_val;
    logic [DATA_W-1:0] alu_a, alu_b, alu_res;
    logic              alu_zero;
    logic              reg_we;
    logic [DATA_W-1:0] reg_wdata;
    logic [DATA_W-1:0] imm9_ext, br_off;

    assign instr = bus.instruction;
    assign rn    = instr[9:5];
    assign rm    = instr[20:16];
    assign rd    = instr[4:0];

    // Decode
    always_comb begin
        is_r    = 1'b0;
        is_ldur = 1'b0;
        is_stur = 1'b0;
        is_cbz  = 1'b0;
        is_b    = 1'b0;
        alu_op  = AluAdd;
        unique case (instr[31:21])
            OpAdd:   begin is_r = 1'b1; alu_op = AluAdd; end
            OpSub:   begin is_r = 1'b1; alu_op = AluSub; end
            OpAnd:   begin is_r = 1'b1; alu_op = AluAnd; end
            OpOrr:   begin is_r = 1'b1; alu_op = AluOrr; end
            OpLdur:  is_ldur = 1'b1;
            OpStur:  is_stur = 1'b1;
            default: begin
                is_cbz = (instr[31:24] == OpCbz);
                is_b   = (instr[31:26] == OpB);
            end
        endcase
    end

    // Register file reads; X31 always reads zero
    always_comb begin
        rn_val = (rn == Xzr) ? '0 : regs_q[rn];
        // Second read port: Rm for R-type, Rt for STUR/CBZ
        if (is_r) begin
            rb_val = (rm == Xzr) ? '0 : regs_q[rm];
        end else begin
            rb_val = (rd == Xzr) ? '0 : regs_q[rd];
        end
    end

    assign imm9_ext = {{(DATA_W-9){instr[20]}}, instr[20:12]};
    assign br_off   = is_b ? {{(DATA_W-28){instr[25]}}, instr[25:0], 2'b00}
                           : {{(DATA_W-21){instr[23]}}, instr[23:5], 2'b00};

    // ALU operand selection: D-type adds the offset to Rn, CBZ tests Rt through the adder
    always_comb begin
        alu_a = rn_val;
        alu_b = rb_val;
        if (is_ldur || is_stur) begin
            alu_b = imm9_ext;
        end else if (is_cbz) begin
            alu_a = '0;
        end
    end

    always_comb begin
        alu_res = '0;
        unique case (alu_op)
            AluAdd: alu_res = alu_a + alu_b;
            AluSub: alu_res = alu_a - alu_b;
            AluAnd: alu_res = alu_a & alu_b;
            AluOrr: alu_res = alu_a | alu_b;
            default: alu_res = '0;
        endcase
    end

    assign alu_zero = (alu_res == '0);

    // Next PC and write-back
    always_comb begin
        pc_d = pc_q + DATA_W'(4);
        if (is_b || (is_cbz && alu_zero)) begin
            pc_d = pc_q + br_off;
        end
    end

    assign reg_we    = (is_r || is_ldur) && (rd != Xzr);
    assign reg_wdata = is_ldur ? bus.mem_data_out : alu_res;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            pc_q <= '0;
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            pc_q <= pc_d;
            if (reg_we) begin
                regs_q[rd] <= reg_wdata;
            end
        end
    end

    // Memory-side outputs are forced quiet while RESET is low, so a store in flight drops at once
    assign bus.PC               = pc_q;
    assign bus.mem_address      = RESET ? alu_res : '0;
    assign bus.mem_data_in      = RESET ? rb_val : '0;
    assign bus.control_memwrite = RESET & is_stur;
    assign bus.control_memread  = RESET & is_ldur;

endmodule

// File: tb/tb_arm_cpu_core.sv
module tb_arm_cpu_core;

    logic CLOCK;
    logic RESET;

    arm_cpu_core_if #(.DATA_W(64), .INSTR_W(32)) bus ();

    arm_cpu_core #(.DATA_W(64), .INSTR_W(32), .NREGS(32)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    // Data memory: 64 doublewords, word-indexed by address[8:3]; preloaded while RESET is low
    logic [63:0] mem [64];
    assign bus.mem_data_out = mem[bus.mem_address[8:3]];

    always @(posedge CLOCK) begin
        if (!RESET) begin
            mem[16] <= 64'd5;    // 0x80
            mem[17] <= 64'd7;    // 0x88
            mem[18] <= 64'hF0;   // 0x90
            mem[19] <= 64'h3C;   // 0x98
        end else if (bus.control_memwrite) begin
            mem[bus.mem_address[8:3]] <= bus.mem_data_in;
        end
    end

    int n_cmp = 0;
    int n_mis = 0;

    localparam logic [10:0] ADD  = 11'b10001011000;
    localparam logic [10:0] SUB  = 11'b11001011000;
    localparam logic [10:0] AND_ = 11'b10001010000;
    localparam logic [10:0] ORR  = 11'b10101010000;
    localparam logic [10:0] LDUR = 11'b11111000010;
    localparam logic [10:0] STUR = 11'b11111000000;

    function automatic logic [31:0] r_ins(logic [10:0] op, logic [4:0] m, logic [4:0] n,
                                          logic [4:0] d);
        return {op, m, 6'd0, n, d};
    endfunction

    function automatic logic [31:0] d_ins(logic [10:0] op, logic [8:0] imm, logic [4:0] n,
                                          logic [4:0] t);
        return {op, imm, 2'b00, n, t};
    endfunction

    function automatic logic [31:0] cbz_ins(logic [18:0] imm, logic [4:0] t);
        return {8'hB4, imm, t};
    endfunction

    function automatic logic [31:0] b_ins(logic [25:0] imm);
        return {6'b000101, imm};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full clock period; returns with CLOCK low, well away from the rising edge
    task automatic tick();
        #5 CLOCK = 1'b1;
        #5 CLOCK = 1'b0;
    endtask

    task automatic step(input logic [31:0] ins);
        bus.instruction = ins;
        #1;
        tick();
    endtask

    // Read a register through the STUR data path without clocking, then restore the instruction
    task automatic peek(input string tag, input logic [4:0] r, input logic [63:0] exp);
        logic [31:0] saved;
        saved = bus.instruction;
        bus.instruction = d_ins(STUR, 9'd0, 5'd31, r);
        #1;
        check(tag, bus.mem_data_in, exp);
        bus.instruction = saved;
        #1;
    endtask

    initial begin
        CLOCK = 1'b0;
        RESET = 1'b0;
        bus.instruction = r_ins(ADD, 5'd2, 5'd1, 5'd3);
        #1;
        tick();
        tick();
        tick();
        check("rst_pc", bus.PC, 64'd0);
        check("rst_memwrite", {63'd0, bus.control_memwrite}, 64'd0);
        check("rst_memread", {63'd0, bus.control_memread}, 64'd0);
        check("rst_addr", bus.mem_address, 64'd0);
        check("rst_data_in", bus.mem_data_in, 64'd0);

        RESET = 1'b1;
        #1;
        peek("rst_x1", 5'd1, 64'd0);
        peek("rst_x30", 5'd30, 64'd0);
        step(r_ins(ADD, 5'd2, 5'd1, 5'd3));
        check("first_pc", bus.PC, 64'd4);
        peek("first_x3", 5'd3, 64'd0);

        // Arithmetic
        bus.instruction = d_ins(LDUR, 9'h080, 5'd31, 5'd1);
        #1;
        check("ldur_memread", {63'd0, bus.control_memread}, 64'd1);
        check("ldur_memwrite", {63'd0, bus.control_memwrite}, 64'd0);
        check("ldur_addr", bus.mem_address, 64'h80);
        tick();
        step(d_ins(LDUR, 9'h088, 5'd31, 5'd2));
        step(r_ins(ADD, 5'd2, 5'd1, 5'd3));
        step(r_ins(SUB, 5'd2, 5'd1, 5'd4));
        check("arith_pc", bus.PC, 64'h14);
        peek("add_x3", 5'd3, 64'd12);
        peek("sub_x4", 5'd4, 64'hFFFF_FFFF_FFFF_FFFE);

        // Logic and store
        step(d_ins(LDUR, 9'h090, 5'd31, 5'd1));
        step(d_ins(LDUR, 9'h098, 5'd31, 5'd2));
        step(r_ins(AND_, 5'd2, 5'd1, 5'd5));
        step(r_ins(ORR, 5'd2, 5'd1, 5'd6));
        bus.instruction = d_ins(STUR, 9'h010, 5'd31, 5'd6);
        #1;
        check("stur_memwrite", {63'd0, bus.control_memwrite}, 64'd1);
        check("stur_memread", {63'd0, bus.control_memread}, 64'd0);
        check("stur_addr", bus.mem_address, 64'h10);
        check("stur_data_in", bus.mem_data_in, 64'hFC);
        tick();
        check("stur_mem", mem[2], 64'hFC);
        check("stur_pc", bus.PC, 64'h28);
        peek("and_x5", 5'd5, 64'h30);

        // CBZ
        step(cbz_ins(19'd2, 5'd31));
        check("cbz_taken_pc", bus.PC, 64'h30);
        step(d_ins(LDUR, 9'h080, 5'd31, 5'd1));
        step(cbz_ins(19'd2, 5'd1));
        check("cbz_not_taken_pc", bus.PC, 64'h38);
        step(cbz_ins(19'h7FFFF, 5'd31));
        check("cbz_back_pc", bus.PC, 64'h34);

        // B and XZR
        step(b_ins(26'h3FFFFFD));
        check("b_back_pc", bus.PC, 64'h28);
        step(r_ins(ADD, 5'd1, 5'd1, 5'd31));
        peek("xzr_write", 5'd31, 64'd0);
        bus.instruction = 32'hFFFF_FFFF;
        #1;
        check("nop_memwrite", {63'd0, bus.control_memwrite}, 64'd0);
        check("nop_memread", {63'd0, bus.control_memread}, 64'd0);
        tick();
        check("nop_pc", bus.PC, 64'h30);
        peek("nop_x1", 5'd1, 64'd5);
        peek("nop_x6", 5'd6, 64'hFC);

        // Negative imm9 store: X6(0xFC) - 4
        bus.instruction = d_ins(STUR, 9'h1FC, 5'd6, 5'd3);
        #1;
        check("neg_imm_addr", bus.mem_address, 64'hF8);
        check("neg_imm_data", bus.mem_data_in, 64'd12);
        tick();
        check("neg_imm_mem", mem[31], 64'd12);

        // Async reset in the middle of a store
        bus.instruction = d_ins(STUR, 9'h010, 5'd31, 5'd6);
        #1;
        check("pre_arst_memwrite", {63'd0, bus.control_memwrite}, 64'd1);
        RESET = 1'b0;
        #1;
        check("arst_memwrite", {63'd0, bus.control_memwrite}, 64'd0);
        check("arst_pc", bus.PC, 64'd0);
        check("arst_addr", bus.mem_address, 64'd0);
        check("arst_data_in", bus.mem_data_in, 64'd0);
        RESET = 1'b1;
        #1;
        peek("arst_x6", 5'd6, 64'd0);
        peek("arst_x1", 5'd1, 64'd0);
        step(32'd0);
        check("arst_resume_pc", bus.PC, 64'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
